// File: rtl/psram_arb_if.sv
// Handshake bundle between psram_arb, its two requesters (AXI memory path,
// APB config path) and the shared psram_core.
interface psram_arb_if #(
  parameter int ADDR_WIDTH = 26
);
  logic                  mem_req_i;
  logic                  mem_wen_i;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [31:0]           mem_wdata_i;
  logic [3:0]            mem_bm_i;
  logic                  mem_ack_o;
  logic [31:0]           mem_rdata_o;
  logic                  mem_err_o;

  logic                  cfg_req_i;
  logic                  cfg_wen_i;
  logic [7:0]            cfg_wdata_i;
  logic                  cfg_ack_o;
  logic [7:0]            cfg_rdata_o;

  logic                  core_start_o;
  logic                  core_cflg_o;
  logic                  core_wen_o;
  logic [ADDR_WIDTH-1:0] core_addr_o;
  logic [31:0]           core_wdata_o;
  logic [3:0]            core_bm_o;
  logic                  core_done_i;
  logic [31:0]           core_rdata_i;

  // Arbiter side
  modport slave (
    input  mem_req_i, mem_wen_i, mem_addr_i, mem_wdata_i, mem_bm_i,
    output mem_ack_o, mem_rdata_o, mem_err_o,
    input  cfg_req_i, cfg_wen_i, cfg_wdata_i,
    output cfg_ack_o, cfg_rdata_o,
    output core_start_o, core_cflg_o, core_wen_o, core_addr_o, core_wdata_o, core_bm_o,
    input  core_done_i, core_rdata_i
  );

  // Requester / core side
  modport master (
    output mem_req_i, mem_wen_i, mem_addr_i, mem_wdata_i, mem_bm_i,
    input  mem_ack_o, mem_rdata_o, mem_err_o,
    output cfg_req_i, cfg_wen_i, cfg_wdata_i,
    input  cfg_ack_o, cfg_rdata_o,
    input  core_start_o, core_cflg_o, core_wen_o, core_addr_o, core_wdata_o, core_bm_o,
    output core_done_i, core_rdata_i
  );
endinterface

// File: rtl/psram_arb.sv
// Round-robin arbiter/sequencer sharing psram_core between the memory and
// config-register paths; one transaction at a time with a completion watchdog.
module psram_arb #(
  parameter int ADDR_WIDTH = 26,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  psram_arb_if.slave  bus,
  output logic        busy_o,
  output logic        tmo_o
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  lastGntCfg_q, lastGntCfg_d;
  logic                  err_q, err_d;
  logic                  coreCflg_q, coreCflg_d;
  logic                  coreWen_q, coreWen_d;
  logic [ADDR_WIDTH-1:0] coreAddr_q, coreAddr_d;
  logic [31:0]           coreWdata_q, coreWdata_d;
  logic [3:0]            coreBm_q, coreBm_d;
  logic [31:0]           memRdata_q, memRdata_d;
  logic [7:0]            cfgRdata_q, cfgRdata_d;

  logic grantMem;
  logic grantCfg;
  logic cntExpired;

  // On a tie, the port that did not win last time takes the grant.
  assign grantMem   = bus.mem_req_i & (~bus.cfg_req_i | lastGntCfg_q);
  assign grantCfg   = bus.cfg_req_i & ~grantMem;
  assign cntExpired = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lastGntCfg_q <= 1'b1;
      err_q        <= 1'b0;
      coreCflg_q   <= 1'b0;
      coreWen_q    <= 1'b0;
      coreAddr_q   <= '0;
      coreWdata_q  <= '0;
      coreBm_q     <= '0;
      memRdata_q   <= '0;
      cfgRdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lastGntCfg_q <= lastGntCfg_d;
      err_q        <= err_d;
      coreCflg_q   <= coreCflg_d;
      coreWen_q    <= coreWen_d;
      coreAddr_q   <= coreAddr_d;
      coreWdata_q  <= coreWdata_d;
      coreBm_q     <= coreBm_d;
      memRdata_q   <= memRdata_d;
      cfgRdata_q   <= cfgRdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lastGntCfg_d = lastGntCfg_q;
    err_d        = err_q;
    coreCflg_d   = coreCflg_q;
    coreWen_d    = coreWen_q;
    coreAddr_d   = coreAddr_q;
    coreWdata_d  = coreWdata_q;
    coreBm_d     = coreBm_q;
    memRdata_d   = memRdata_q;
    cfgRdata_d   = cfgRdata_q;
    tmo_o        = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_i && (grantMem || grantCfg)) begin
          state_d      = START;
          lastGntCfg_d = grantCfg;
          coreCflg_d   = grantCfg;
          if (grantCfg) begin
            coreWen_d   = bus.cfg_wen_i;
            coreAddr_d  = '0;
            coreWdata_d = {24'd0, bus.cfg_wdata_i};
            coreBm_d    = 4'b0001;
          end else begin
            coreWen_d   = bus.mem_wen_i;
            coreAddr_d  = bus.mem_addr_i;
            coreWdata_d = bus.mem_wdata_i;
            coreBm_d    = bus.mem_bm_i;
          end
        end
      end

      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      // A done arriving in the same cycle as expiry counts as success.
      WAIT: begin
        if (bus.core_done_i) begin
          err_d   = 1'b0;
          state_d = RESP;
          if (coreCflg_q) begin
            cfgRdata_d = bus.core_rdata_i[7:0];
          end else begin
            memRdata_d = bus.core_rdata_i;
          end
        end else if (cntExpired) begin
          err_d   = 1'b1;
          tmo_o   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o           = (state_q != IDLE);
  assign bus.core_start_o = (state_q == START);
  assign bus.core_cflg_o  = coreCflg_q;
  assign bus.core_wen_o   = coreWen_q;
  assign bus.core_addr_o  = coreAddr_q;
  assign bus.core_wdata_o = coreWdata_q;
  assign bus.core_bm_o    = coreBm_q;

  assign bus.mem_ack_o    = (state_q == RESP) & ~coreCflg_q;
  assign bus.mem_err_o    = (state_q == RESP) & ~coreCflg_q & err_q;
  assign bus.mem_rdata_o  = memRdata_q;
  assign bus.cfg_ack_o    = (state_q == RESP) & coreCflg_q;
  assign bus.cfg_rdata_o  = cfgRdata_q;

endmodule
